// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch sequencer.
//   fetch_state_e    : sequencer state (idle / fetching / dropping a wrong-path ack)
//   QUEUE_DEPTH      : entries in the fetch buffer
//   PC_STEP          : byte distance between sequential instructions
//   DEFAULT_RESET_PC : PC after reset unless overridden
package fetch_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StDrop  = 2'd2
    } fetch_state_e;

    localparam int unsigned QUEUE_DEPTH      = 2;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Instruction addresses are always word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: 2-entry FIFO of {instr, pc} between the memory port and decode.
//   clk, rst_n              : clock, asynchronous active-low reset
//   flush                   : empty the FIFO (wins over push/pop)
//   push, push_instr/pc     : write one entry at the tail
//   pop                     : retire the head (caller guarantees count != 0)
//   count                   : number of valid entries
//   head_instr, head_pc     : registered head entry
module fetch_buffer
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        push,
    input  logic [31:0] push_instr,
    input  logic [31:0] push_pc,
    input  logic        pop,
    output logic [1:0]  count,
    output logic [31:0] head_instr,
    output logic [31:0] head_pc
);

    logic [QUEUE_DEPTH-1:0][31:0] instr_q, instr_d;
    logic [QUEUE_DEPTH-1:0][31:0] pc_q, pc_d;
    logic                         rd_ptr_q, rd_ptr_d;
    logic                         wr_ptr_q, wr_ptr_d;
    logic [1:0]                   count_q, count_d;

    always_comb begin
        instr_d  = instr_q;
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) begin
                instr_d[wr_ptr_q] = push_instr;
                pc_d[wr_ptr_q]    = push_pc;
                wr_ptr_d          = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q  <= '0;
            pc_q     <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            instr_q  <= instr_d;
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count      = count_q;
    assign head_instr = instr_q[rd_ptr_q];
    assign head_pc    = pc_q[rd_ptr_q];

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction fetch stage sequencer. Owns the PC, issues one
// outstanding request at a time to instruction memory, buffers fetched words in
// fetch_buffer and hands them to decode; branch redirects flush wrong-path work.
//   RESET_PC                     : PC after reset
//   clk, rst_n                   : clock, asynchronous active-low reset
//   en                           : fetch enable
//   imem_req/addr, ack/rdata     : instruction memory request/response
//   br_valid, br_pc, br_offset   : redirect to (br_pc + br_offset) & ~3
//   stall, id_ready              : block hand-off to decode
//   if_valid, if_instr, if_pc    : head of the fetch queue
//   perf_*_cnt                   : performance counters, only with FETCH_PERF_CNT_EN
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        br_valid,
    input  logic [31:0] br_pc,
    input  logic [31:0] br_offset,
    input  logic        stall,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_redirect_cnt
`endif
);

    localparam logic [1:0] QueueDepthCnt = 2'(QUEUE_DEPTH);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  drop_addr_q, drop_addr_d;
    logic         outstanding_q, outstanding_d;
    logic [1:0]   count;
    logic         push, pop;
    logic         req_pending;

    // A request raised this cycle and not acked this cycle stays owed to memory.
    assign req_pending   = imem_req && !imem_ack;
    assign outstanding_d = req_pending;
    assign if_valid      = (count != 2'd0);
    assign pop           = if_valid && id_ready && !stall;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_addr_d = drop_addr_q;
        imem_req    = 1'b0;
        imem_addr   = pc_q;
        push        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (en) state_d = StFetch;
            end
            StFetch: begin
                // count < depth with nothing owed covers count + outstanding < 2.
                imem_req = outstanding_q || (count < QueueDepthCnt);
                if (imem_req && imem_ack) begin
                    push = 1'b1;
                    pc_d = pc_q + PC_STEP;
                end
                if (!en && !req_pending) state_d = StIdle;
            end
            StDrop: begin
                // Hold the wrong-path request until memory answers, then discard it.
                imem_req  = 1'b1;
                imem_addr = drop_addr_q;
                if (imem_ack) state_d = StFetch;
            end
            default: state_d = StIdle;
        endcase

        // Redirect overrides push and the en transition.
        if (br_valid) begin
            push = 1'b0;
            pc_d = word_align(br_pc + br_offset);
            case (state_q)
                StIdle: state_d = StIdle;
                StFetch: begin
                    if (req_pending) begin
                        state_d     = StDrop;
                        drop_addr_d = pc_q;
                    end else begin
                        state_d = StFetch;
                    end
                end
                StDrop:  state_d = imem_ack ? StFetch : StDrop;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            pc_q          <= RESET_PC;
            drop_addr_q   <= RESET_PC;
            outstanding_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            drop_addr_q   <= drop_addr_d;
            outstanding_q <= outstanding_d;
        end
    end

    fetch_buffer u_buffer (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (br_valid),
        .push       (push),
        .push_instr (imem_rdata),
        .push_pc    (pc_q),
        .pop        (pop && !br_valid),
        .count      (count),
        .head_instr (if_instr),
        .head_pc    (if_pc)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_redirect_q, perf_redirect_d;

    always_comb begin
        perf_fetch_d    = perf_fetch_q + (push ? 32'd1 : 32'd0);
        perf_stall_d    = perf_stall_q + ((if_valid && (stall || !id_ready)) ? 32'd1 : 32'd0);
        perf_redirect_d = perf_redirect_q + (br_valid ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_q    <= '0;
            perf_stall_q    <= '0;
            perf_redirect_q <= '0;
        end else begin
            perf_fetch_q    <= perf_fetch_d;
            perf_stall_q    <= perf_stall_d;
            perf_redirect_q <= perf_redirect_d;
        end
    end

    assign perf_fetch_cnt    = perf_fetch_q;
    assign perf_stall_cnt    = perf_stall_q;
    assign perf_redirect_cnt = perf_redirect_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed cycle table plus randomized run against a
// transaction-level model (program-order PC stream, memory latency model).
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        br_valid;
    logic [31:0] br_pc;
    logic [31:0] br_offset;
    logic        stall;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt, perf_redirect_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    fetch_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .br_valid   (br_valid),
        .br_pc      (br_pc),
        .br_offset  (br_offset),
        .stall      (stall),
        .id_ready   (id_ready),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_pc      (if_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt    (perf_fetch_cnt),
        .perf_stall_cnt    (perf_stall_cnt),
        .perf_redirect_cnt (perf_redirect_cnt)
`endif
    );

    typedef struct {
        logic        en, ack, rdy, stl, br;
        logic [31:0] bpc, boff;
        logic        ereq;
        logic [31:0] eaddr;
        logic        evalid;
        logic [31:0] epc;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic e, input logic a, input logic r, input logic s,
                                input logic b, input logic [31:0] bp, input logic [31:0] bo,
                                input logic rq, input logic [31:0] ad, input logic v,
                                input logic [31:0] p);
        vec_t t;
        t.en = e; t.ack = a; t.rdy = r; t.stl = s; t.br = b; t.bpc = bp; t.boff = bo;
        t.ereq = rq; t.eaddr = ad; t.evalid = v; t.epc = p;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b0; imem_ack = 1'b0; br_valid = 1'b0; br_pc = '0;
        br_offset = '0; stall = 1'b0; id_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Random-phase model state
    logic [31:0] exp_pc, prev_addr, tgt;
    logic        pend_prev, flush_prev, discard;
    int          mem_wait, pops;
    int unsigned exp_fetch, exp_stall, exp_redir;

    initial begin
        //       en ack rdy stl br  br_pc          br_off     req addr           v  pc
        vq.push_back(mk(1, 0, 1, 0, 0, 0, 0,            0, 0,             0, 0));
        vq.push_back(mk(1, 1, 1, 0, 0, 0, 0,            1, 32'h0,         0, 0));
        vq.push_back(mk(1, 1, 1, 0, 0, 0, 0,            1, 32'h4,         1, 32'h0));
        vq.push_back(mk(1, 1, 1, 0, 0, 0, 0,            1, 32'h8,         1, 32'h4));
        vq.push_back(mk(1, 1, 0, 0, 0, 0, 0,            1, 32'hC,         1, 32'h8));
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 0,            0, 0,             1, 32'h8));
        vq.push_back(mk(1, 0, 1, 1, 0, 0, 0,            0, 0,             1, 32'h8));
        vq.push_back(mk(1, 0, 1, 0, 0, 0, 0,            0, 0,             1, 32'h8));
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 0,            1, 32'h10,        1, 32'hC));
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 0,            1, 32'h10,        1, 32'hC));
        vq.push_back(mk(1, 1, 0, 0, 0, 0, 0,            1, 32'h10,        1, 32'hC));
        vq.push_back(mk(1, 0, 1, 0, 0, 0, 0,            0, 0,             1, 32'hC));
        vq.push_back(mk(1, 0, 1, 0, 0, 0, 0,            1, 32'h14,        1, 32'h10));
        vq.push_back(mk(1, 0, 1, 0, 0, 0, 0,            1, 32'h14,        0, 0));
        vq.push_back(mk(1, 1, 1, 0, 0, 0, 0,            1, 32'h14,        0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,            1, 32'h18,        1, 32'h14));
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 0,            1, 32'h18,        1, 32'h14));
        vq.push_back(mk(0, 0, 1, 0, 0, 0, 0,            0, 0,             1, 32'h14));
        vq.push_back(mk(0, 0, 1, 0, 0, 0, 0,            0, 0,             1, 32'h18));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,            0, 0,             0, 0));
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 0,            0, 0,             0, 0));
        vq.push_back(mk(1, 1, 0, 0, 0, 0, 0,            1, 32'h1C,        0, 0));
        vq.push_back(mk(1, 1, 0, 0, 0, 0, 0,            1, 32'h20,        1, 32'h1C));
        vq.push_back(mk(1, 0, 0, 0, 1, 32'h10, 32'h20,  0, 0,             1, 32'h1C));
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 0,            1, 32'h30,        0, 0));
        vq.push_back(mk(1, 0, 0, 0, 1, 32'h100, 32'h9,  1, 32'h30,        0, 0));
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 0,            1, 32'h30,        0, 0));
        vq.push_back(mk(1, 1, 0, 0, 0, 0, 0,            1, 32'h30,        0, 0));
        vq.push_back(mk(1, 1, 1, 0, 0, 0, 0,            1, 32'h108,       0, 0));
        vq.push_back(mk(1, 0, 1, 0, 0, 0, 0,            1, 32'h10C,       1, 32'h108));
        vq.push_back(mk(0, 1, 1, 0, 0, 0, 0,            1, 32'h10C,       0, 0));
        vq.push_back(mk(0, 0, 1, 0, 0, 0, 0,            0, 0,             1, 32'h10C));
        vq.push_back(mk(0, 0, 0, 0, 1, 32'hFFFFFFF0, 32'hC, 0, 0,         0, 0));
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 0,            0, 0,             0, 0));
        vq.push_back(mk(1, 1, 1, 0, 0, 0, 0,            1, 32'hFFFFFFFC,  0, 0));
        vq.push_back(mk(1, 1, 1, 0, 1, 32'h40, 32'h0,   1, 32'h0,         1, 32'hFFFFFFFC));
        vq.push_back(mk(1, 1, 1, 0, 0, 0, 0,            1, 32'h40,        0, 0));
        vq.push_back(mk(0, 0, 1, 0, 0, 0, 0,            1, 32'h44,        1, 32'h40));
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 0,            1, 32'h44,        0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,            0, 0,             1, 32'h44));

        do_reset();
        check("reset_req", 32'(imem_req), 32'd0);
        check("reset_valid", 32'(if_valid), 32'd0);
        check("reset_pc", if_pc, 32'd0);
        check("reset_instr", if_instr, 32'd0);

        foreach (vq[i]) begin
            en = vq[i].en; imem_ack = vq[i].ack; id_ready = vq[i].rdy; stall = vq[i].stl;
            br_valid = vq[i].br; br_pc = vq[i].bpc; br_offset = vq[i].boff;
            #1;
            check($sformatf("r%0d_req", i), 32'(imem_req), 32'(vq[i].ereq));
            if (vq[i].ereq) check($sformatf("r%0d_addr", i), imem_addr, vq[i].eaddr);
            check($sformatf("r%0d_valid", i), 32'(if_valid), 32'(vq[i].evalid));
            if (vq[i].evalid) begin
                check($sformatf("r%0d_pc", i), if_pc, vq[i].epc);
                check($sformatf("r%0d_instr", i), if_instr, mem_word(vq[i].epc));
            end
            step();
        end

        // Asynchronous reset while a request is outstanding.
        en = 1'b1; imem_ack = 1'b0; br_valid = 1'b0; id_ready = 1'b0; stall = 1'b0;
        step();
        step();
        check("midrst_req_before", 32'(imem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_req", 32'(imem_req), 32'd0);
        check("midrst_valid", 32'(if_valid), 32'd0);
        check("midrst_pc", if_pc, 32'd0);
        check("midrst_instr", if_instr, 32'd0);
        step();
        rst_n = 1'b1;
        check("midrst_idle", 32'(imem_req), 32'd0);
        step();
        check("midrst_first_req", 32'(imem_req), 32'd1);
        check("midrst_first_addr", imem_addr, 32'd0);

        // Randomized run against the program-order model.
        do_reset();
        exp_pc = 32'd0; pend_prev = 1'b0; flush_prev = 1'b0; discard = 1'b0;
        prev_addr = '0; mem_wait = -1; pops = 0;
        exp_fetch = 0; exp_stall = 0; exp_redir = 0;
        for (int c = 0; c < 3000; c++) begin
            en        = ($urandom_range(0, 15) != 0);
            id_ready  = ($urandom_range(0, 3) != 0);
            stall     = ($urandom_range(0, 7) == 0);
            br_valid  = ($urandom_range(0, 19) == 0);
            br_pc     = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : $urandom;
            br_offset = $urandom_range(0, 255);
            if (imem_req) begin
                if (mem_wait < 0) mem_wait = $urandom_range(0, 3);
                imem_ack = (mem_wait == 0);
            end else begin
                imem_ack = 1'b0;
            end
            #1;
            if (pend_prev) begin
                check("rand_req_held", 32'(imem_req), 32'd1);
                check("rand_addr_stable", imem_addr, prev_addr);
            end
            if (flush_prev) check("rand_flush_valid", 32'(if_valid), 32'd0);
            if (if_valid && id_ready && !stall) begin
                check("rand_pop_pc", if_pc, exp_pc);
                check("rand_pop_instr", if_instr, mem_word(exp_pc));
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            if (if_valid && (stall || !id_ready)) exp_stall++;
            if (imem_req && imem_ack) begin
                if (!br_valid && !discard) exp_fetch++;
                discard = 1'b0;
            end
            if (br_valid) begin
                exp_redir++;
                tgt = br_pc + br_offset;
                exp_pc = {tgt[31:2], 2'b00};
                if (imem_req && !imem_ack) discard = 1'b1;
            end
            pend_prev  = imem_req && !imem_ack;
            prev_addr  = imem_addr;
            flush_prev = br_valid;
            if (imem_ack) mem_wait = -1;
            else if (imem_req) mem_wait--;
            step();
        end
        check("rand_progress", 32'(pops >= 200), 32'd1);
`ifdef FETCH_PERF_CNT_EN
        check("perf_fetch", perf_fetch_cnt, exp_fetch);
        check("perf_stall", perf_stall_cnt, exp_stall);
        check("perf_redirect", perf_redirect_cnt, exp_redir);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Sequencer for the instruction fetch stage. Owns the program counter, issues requests to instruction memory over a req/ack handshake and buffers fetched words in a 2-entry queue. It presents instructions to decode over a valid/ready handshake and applies branch redirects from execute, discarding wrong-path fetches. Sits between the instruction memory port and the IF/ID boundary.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value after reset.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: fetch enable.
- `imem_req` out 1: fetch request to instruction memory.
- `imem_addr` out 32: fetch address; word aligned.
- `imem_ack` in 1: memory response valid; may assert in the same cycle as `imem_req`.
- `imem_rdata` in 32: instruction word, valid with `imem_ack`.
- `br_valid` in 1: single-cycle redirect pulse from execute.
- `br_pc` in 32: PC of the branch.
- `br_offset` in 32: byte offset; target = `br_pc` + `br_offset`.
- `stall` in 1: hazard stall; blocks hand-off to decode.
- `id_ready` in 1: decode can accept.
- `if_valid` out 1: queue head valid.
- `if_instr` out 32: head instruction.
- `if_pc` out 32: head PC.
- `perf_fetch_cnt`, `perf_stall_cnt`, `perf_redirect_cnt` out 32 each: present only with `FETCH_PERF_CNT_EN`.

## Operation
- Reset values: state IDLE, `pc` = `RESET_PC`, queue count 0, `imem_req` 0, `if_valid` 0, `if_instr` 0, `if_pc` 0, counters 0.
- Pop when `if_valid && id_ready && !stall`. `if_valid` = (count != 0). Outputs come from registered queue storage.
- IDLE: `imem_req` = 0. On `en` = 1, go to FETCH.
- FETCH: `imem_req` = 1 when count + outstanding < 2. At most one request is outstanding. `imem_addr` = `pc`.
  - Once raised, `imem_req` and `imem_addr` stay stable until `imem_ack`.
  - On ack: push {`imem_rdata`, `pc`} and set `pc` = `pc` + 4, which wraps modulo 2^32.
  - If `en` = 0 and nothing is outstanding, go to IDLE. The queue keeps its contents and drains normally.
- DROP: entered when `br_valid` arrives while a request is outstanding and unacked. `imem_req` stays high at the old address. The ack data is discarded, then the state returns to FETCH at the new `pc`.
- Redirect (`br_valid`), in any state:
  - Flush the queue, so count = 0 next cycle.
  - `pc` = (`br_pc` + `br_offset`) with bits [1:0] cleared.
  - An ack in the same cycle as `br_valid` is discarded, not pushed, and no DROP is needed.
  - A pop in the same cycle completes as a handshake. Decode flushes its own stage.
  - Redirect has priority over push, pop and the `en` transition.
  - A redirect in IDLE updates `pc` only.
- Pop and push in the same cycle keep count unchanged. Push is impossible when count = 2, guaranteed by the issue rule.
- `stall` and `!id_ready` only block pop. Fetching continues until the queue is full.
- Reset asserted mid-operation returns to reset values immediately. An outstanding request is abandoned, so the memory must tolerate a dropped req.

## Timing
- `en` rises in cycle 0 → `imem_req` = 1 in cycle 1. A zero-wait ack in cycle 1 → `if_valid` = 1 in cycle 2.
- Steady-state throughput is 1 instruction/cycle with zero-wait memory and decode always ready.
- `br_valid` in cycle n with nothing outstanding → `imem_req` at the target in cycle n+1, and the target instruction at the head in cycle n+2.
- With a request outstanding, the first target request is issued in the cycle after the DROP ack.

## Configuration
- `FETCH_PERF_CNT_EN` defined: the three counter ports and registers exist. All counters are 32-bit and wrap.
  - `perf_fetch_cnt`: +1 per pushed ack.
  - `perf_stall_cnt`: +1 per cycle with `if_valid && (stall || !id_ready)`.
  - `perf_redirect_cnt`: +1 per `br_valid`.
- Undefined: the ports and logic are absent, and all other behaviour is identical.

## Structure
- Package `fetch_pkg` holds:
  - the state enum {IDLE, FETCH, DROP}
  - `QUEUE_DEPTH` = 2
  - the `PC_STEP` = 4 constant
  - the default reset PC
- Sub-module `fetch_buffer`: 2-entry FIFO of {instr, pc} with synchronous flush, push/pop, count and head outputs.

## Test plan
- Reset, then `en` = 1 with zero-wait ack and `id_ready` = 1 → `imem_addr` 0, 4, 8 on consecutive cycles, with `if_pc` following one cycle behind.
- Hold `id_ready` = 0 → exactly 2 pushes, then `imem_req` = 0. Release → pops in order at PCs 0 then 4, and fetching resumes at 8.
- Ack delayed 3 cycles → `imem_addr` is stable throughout and `if_valid` rises the cycle after the ack.
- `br_valid` with `br_pc` = 0x10 and `br_offset` = 0x20 while the queue is full → `if_valid` = 0 next cycle and the next `imem_addr` is 0x30.
- `br_valid` while a request to 0x8 is outstanding, ack 2 cycles later → the 0x8 data is never presented, and the next request goes to the target.
- With `pc` = 0xFFFF_FFFC → the next address is 0x0. With `FETCH_PERF_CNT_EN`, after 5 fetches, 2 stall cycles and 1 redirect, the counters read 5/2/1.
